// File: rtl/step_conditioner.sv
// -----------------------------------------------------------------------------
// step_conditioner
//
// Input stage for the 4-bit up/down counter. Two raw push-button inputs are
// synchronized, debounced, and turned into a single-cycle count pulse
// (with auto-repeat while held) and a direction level that stays frozen for
// the whole of a press / repeat burst.
//
// Ports:
//   clk          : single clock, rising-edge
//   rst          : asynchronous, active-high reset
//   btn_step_raw : raw step button (async), 1 = pressed
//   btn_dir_raw  : raw direction switch (async), 1 = up
//   step_pulse   : one-cycle count-enable pulse (registered)
//   dir_up       : direction to counter, 1 = increment (registered)
//   held         : step press accepted, FSM not idle (registered)
//   repeating    : auto-repeat active (registered)
// -----------------------------------------------------------------------------
module step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step_raw,
  input  logic btn_dir_raw,
  output logic step_pulse,
  output logic dir_up,
  output logic held,
  output logic repeating
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

  // Bit 0 = step, bit 1 = direction; both go through identical conditioning.
  logic [1:0] raw_in;
  logic [1:0] level;

  assign raw_in = {btn_dir_raw, btn_step_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic             meta_reg;
      logic             sync_reg;
      logic             level_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg  <= 1'b0;
          sync_reg  <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
          if (sync_reg != level_reg) begin
            // '>=' rather than '==' keeps the counter saturated: it can
            // never run past the flip point and wrap.
            if (cnt_reg >= CNT_LAST) begin
              level_reg <= ~level_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign level[gi] = level_reg;
    end
  endgenerate

  logic step_level;
  logic dir_level;

  assign step_level = level[0];
  assign dir_level  = level[1];

  // ---------------------------------------------------------------------------
  // Step FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             step_prev_reg;
  logic             pulse_next;
  logic             step_pulse_reg;
  logic             dir_up_reg;
  logic             held_reg;
  logic             repeating_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (step_level && !step_prev_reg) begin
          pulse_next = 1'b1;
          timer_next = DELAY_LOAD;
          state_next = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so an expiring timer cannot fire a pulse
        // on the cycle the button is let go.
        if (!step_level) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          pulse_next = 1'b1;
          timer_next = PERIOD_LOAD;
          state_next = ST_REPEAT;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!step_level) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          pulse_next = 1'b1;
          timer_next = PERIOD_LOAD;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      step_prev_reg  <= 1'b0;
      step_pulse_reg <= 1'b0;
      dir_up_reg     <= 1'b1;
      held_reg       <= 1'b0;
      repeating_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      step_prev_reg  <= step_level;
      step_pulse_reg <= pulse_next;
      held_reg       <= (state_next != ST_IDLE);
      repeating_reg  <= (state_next == ST_REPEAT);
      // Direction only tracks while idle, so a burst keeps one direction.
      if (state_reg == ST_IDLE) begin
        dir_up_reg <= dir_level;
      end
    end
  end

  assign step_pulse = step_pulse_reg;
  assign dir_up     = dir_up_reg;
  assign held       = held_reg;
  assign repeating  = repeating_reg;

endmodule
